// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer and its up-counter sibling.
package countdown_pkg;

   // Timer control states
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Bits needed to hold values 0..max_value
   function automatic int unsigned count_width(input int unsigned max_value);
      return (max_value < 1) ? 1 : $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// tick_prescaler: emits one tick every PRESCALE enabled cycles.
// With PRESCALE = 1 the tick is the enable itself and no phase register exists.
module tick_prescaler #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   if (PRESCALE <= 1) begin : g_bypass
      logic unused_inputs;

      // No division needed: every enabled cycle is a step
      assign unused_inputs = ^{clk, rst_n, clear};
      assign tick          = enable;
   end else begin : g_divide
      localparam int unsigned PW = $clog2(PRESCALE);

      logic [PW-1:0] phase;
      logic          wrap;

      assign wrap = (phase == PW'(PRESCALE - 1));
      assign tick = enable & wrap;

      // Phase counter: advances only when enabled, so pauses keep the phase
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            phase <= '0;
         end else if (clear) begin
            phase <= '0;
         end else if (enable) begin
            phase <= wrap ? '0 : phase + PW'(1);
         end
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with start/abort and a done pulse.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN turns it into a periodic pulse generator.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter  int unsigned MAX_COUNTER_VALUE = 10,
   parameter  int unsigned PRESCALE          = 1,
   localparam int unsigned W                 = count_width(MAX_COUNTER_VALUE)
) (
   input  logic         clock_i,
   input  logic         reset_n_i,
   input  logic         start_i,
   input  logic [W-1:0] load_val_i,
   input  logic         enable_i,
   input  logic         abort_i,
   output logic         busy_o,
   output logic         finished_o,
   output logic [W-1:0] counter_val_o
);

   state_e       state_q;
   state_e       state_nxt;
   logic [W-1:0] clamped_val;
   logic [W-1:0] cnt_nxt;
   logic         busy_nxt;
   logic         fin_nxt;
   logic         presc_clr;
   logic         presc_en;
   logic         tick;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [W-1:0] reload_q;
   logic [W-1:0] reload_nxt;
`endif

   // Saturate oversized start values to the configured maximum
   assign clamped_val = (load_val_i > W'(MAX_COUNTER_VALUE)) ? W'(MAX_COUNTER_VALUE)
                                                            : load_val_i;
   assign presc_en    = enable_i & (state_q == RUN);

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk    (clock_i),
      .rst_n  (reset_n_i),
      .clear  (presc_clr),
      .enable (presc_en),
      .tick   (tick)
   );

   // Next-state and next-output decode
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = counter_val_o;
      busy_nxt  = busy_o;
      fin_nxt   = 1'b0;
      presc_clr = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_nxt = reload_q;
`endif
      unique case (state_q)
         IDLE: begin
            busy_nxt = 1'b0;
            if (start_i && !abort_i) begin
               presc_clr = 1'b1;
               if (clamped_val == '0) begin
                  // Zero-length delay completes at once without going busy
                  cnt_nxt = '0;
                  fin_nxt = 1'b1;
               end else begin
                  cnt_nxt   = clamped_val;
                  busy_nxt  = 1'b1;
                  state_nxt = RUN;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  reload_nxt = clamped_val;
`endif
               end
            end
         end
         RUN: begin
            if (abort_i) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               busy_nxt  = 1'b0;
               presc_clr = 1'b1;
            end else if (tick) begin
               if (counter_val_o <= W'(1)) begin
                  fin_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  cnt_nxt = reload_q;
`else
                  cnt_nxt   = '0;
                  busy_nxt  = 1'b0;
                  state_nxt = IDLE;
`endif
               end else begin
                  cnt_nxt = counter_val_o - W'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q       <= IDLE;
         counter_val_o <= '0;
         busy_o        <= 1'b0;
         finished_o    <= 1'b0;
      end else begin
         state_q       <= state_nxt;
         counter_val_o <= cnt_nxt;
         busy_o        <= busy_nxt;
         finished_o    <= fin_nxt;
      end
   end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   // Reload value captured on each accepted start
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         reload_q <= '0;
      end else begin
         reload_q <= reload_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (PRESCALE 1 and 2 instances).
module tb_countdown_timer;

   typedef struct packed {
      logic       busy;
      logic       fin;
      logic [3:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       start2 = 1'b0;
   logic       abort = 1'b0;
   logic       abort2 = 1'b0;
   logic       enable = 1'b1;
   logic [3:0] load_val = 4'd0;
   logic       busy, fin, busy2, fin2;
   logic [3:0] cnt, cnt2;

   exp_t exp_q[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   countdown_timer #(.MAX_COUNTER_VALUE(10), .PRESCALE(1)) dut (
      .clock_i       (clk),
      .reset_n_i     (rst_n),
      .start_i       (start),
      .load_val_i    (load_val),
      .enable_i      (enable),
      .abort_i       (abort),
      .busy_o        (busy),
      .finished_o    (fin),
      .counter_val_o (cnt)
   );

   countdown_timer #(.MAX_COUNTER_VALUE(10), .PRESCALE(2)) dut2 (
      .clock_i       (clk),
      .reset_n_i     (rst_n),
      .start_i       (start2),
      .load_val_i    (load_val),
      .enable_i      (enable),
      .abort_i       (abort2),
      .busy_o        (busy2),
      .finished_o    (fin2),
      .counter_val_o (cnt2)
   );

   function automatic exp_t mk(input logic b, input logic f, input logic [3:0] c);
      exp_t r;
      r.busy = b;
      r.fin  = f;
      r.cnt  = c;
      return r;
   endfunction

   task automatic test_reset();
      // power-on reset held for 2 edges
      for (int i = 0; i < 2; i++) exp_q.push_back(mk(1'b0, 1'b0, 4'd0));
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({busy, fin, cnt} !== e) begin
            errors++;
            $display("FAIL reset_por cyc%0d got=%b exp=%b", i, {busy, fin, cnt}, e);
         end
      end
      rst_n = 1'b1;
      // run to value 4, then reset asynchronously mid-count
      load_val = 4'd6;
      start = 1'b1;
      exp_q.push_back(mk(1'b1, 1'b0, 4'd6));
      exp_q.push_back(mk(1'b1, 1'b0, 4'd5));
      exp_q.push_back(mk(1'b1, 1'b0, 4'd4));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if ({busy, fin, cnt} !== e) begin
            errors++;
            $display("FAIL reset_pre cyc%0d got=%b exp=%b", i, {busy, fin, cnt}, e);
         end
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, fin, cnt} !== 6'b0) begin
         errors++;
         $display("FAIL reset_async got=%b exp=%b", {busy, fin, cnt}, 6'b0);
      end
      for (int i = 0; i < 5; i++) exp_q.push_back(mk(1'b0, 1'b0, 4'd0));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (i == 1) rst_n = 1'b1;
         e = exp_q.pop_front();
         checks++;
         if ({busy, fin, cnt} !== e) begin
            errors++;
            $display("FAIL reset_post cyc%0d got=%b exp=%b", i, {busy, fin, cnt}, e);
         end
      end
   endtask

   task automatic test_basic(input logic [3:0] n);
      for (int v = n; v >= 1; v--) exp_q.push_back(mk(1'b1, 1'b0, 4'(v)));
      exp_q.push_back(mk(1'b0, 1'b1, 4'd0));
      exp_q.push_back(mk(1'b0, 1'b0, 4'd0));
      load_val = n;
      start = 1'b1;
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         start = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if ({busy, fin, cnt} !== e) begin
            errors++;
            $display("FAIL basic_n%0d got=%b exp=%b", n, {busy, fin, cnt}, e);
         end
      end
   endtask

   task automatic test_prescale2();
      // each value held two cycles: busy for 10 cycles with load 5
      for (int v = 5; v >= 1; v--) begin
         exp_q.push_back(mk(1'b1, 1'b0, 4'(v)));
         exp_q.push_back(mk(1'b1, 1'b0, 4'(v)));
      end
      exp_q.push_back(mk(1'b0, 1'b1, 4'd0));
      exp_q.push_back(mk(1'b0, 1'b0, 4'd0));
      load_val = 4'd5;
      start2 = 1'b1;
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         start2 = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if ({busy2, fin2, cnt2} !== e) begin
            errors++;
            $display("FAIL prescale2 got=%b exp=%b", {busy2, fin2, cnt2}, e);
         end
      end
   endtask

   task automatic test_pause();
      int idx;
      int seq[10] = '{5, 4, 3, 3, 3, 3, 2, 1, 0, 0};
      for (int i = 0; i < 10; i++)
         exp_q.push_back(mk(seq[i] != 0, i == 8, 4'(seq[i])));
      load_val = 4'd5;
      start = 1'b1;
      idx = 0;
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (idx == 2) enable = 1'b0;
         if (idx == 5) enable = 1'b1;
         e = exp_q.pop_front();
         checks++;
         if ({busy, fin, cnt} !== e) begin
            errors++;
            $display("FAIL pause cyc%0d got=%b exp=%b", idx, {busy, fin, cnt}, e);
         end
         idx++;
      end
   endtask

   task automatic test_pause_phase();
      // pause at prescaler phase 1: the first enabled cycle after resume must step
      int idx;
      int seq[11] = '{3, 3, 3, 3, 3, 2, 2, 1, 1, 0, 0};
      for (int i = 0; i < 11; i++)
         exp_q.push_back(mk(seq[i] != 0, i == 9, 4'(seq[i])));
      load_val = 4'd3;
      start2 = 1'b1;
      idx = 0;
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         start2 = 1'b0;
         if (idx == 1) enable = 1'b0;
         if (idx == 4) enable = 1'b1;
         e = exp_q.pop_front();
         checks++;
         if ({busy2, fin2, cnt2} !== e) begin
            errors++;
            $display("FAIL pause_phase cyc%0d got=%b exp=%b", idx, {busy2, fin2, cnt2}, e);
         end
         idx++;
      end
   endtask

   task automatic test_abort();
      int idx;
      int seq[6] = '{5, 4, 3, 0, 0, 0};
      for (int i = 0; i < 6; i++) exp_q.push_back(mk(seq[i] != 0, 1'b0, 4'(seq[i])));
      load_val = 4'd5;
      start = 1'b1;
      idx = 0;
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         start = 1'b0;
         abort = (idx == 2);
         e = exp_q.pop_front();
         checks++;
         if ({busy, fin, cnt} !== e) begin
            errors++;
            $display("FAIL abort_run cyc%0d got=%b exp=%b", idx, {busy, fin, cnt}, e);
         end
         idx++;
      end
      // start and abort together in IDLE: nothing loaded
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, 1'b0, 4'd0));
      load_val = 4'd7;
      start = 1'b1;
      abort = 1'b1;
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         start = 1'b0;
         abort = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if ({busy, fin, cnt} !== e) begin
            errors++;
            $display("FAIL abort_start got=%b exp=%b", {busy, fin, cnt}, e);
         end
      end
   endtask

   task automatic test_clamp();
      for (int v = 10; v >= 1; v--) exp_q.push_back(mk(1'b1, 1'b0, 4'(v)));
      exp_q.push_back(mk(1'b0, 1'b1, 4'd0));
      exp_q.push_back(mk(1'b0, 1'b0, 4'd0));
      load_val = 4'd15;
      start = 1'b1;
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         start = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if ({busy, fin, cnt} !== e) begin
            errors++;
            $display("FAIL clamp got=%b exp=%b", {busy, fin, cnt}, e);
         end
      end
   endtask

   task automatic test_zero_load();
      exp_q.push_back(mk(1'b0, 1'b1, 4'd0));
      exp_q.push_back(mk(1'b0, 1'b0, 4'd0));
      exp_q.push_back(mk(1'b0, 1'b0, 4'd0));
      load_val = 4'd0;
      start = 1'b1;
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         start = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if ({busy, fin, cnt} !== e) begin
            errors++;
            $display("FAIL zero_load got=%b exp=%b", {busy, fin, cnt}, e);
         end
      end
   endtask

   task automatic test_start_in_run();
      int idx;
      for (int v = 4; v >= 1; v--) exp_q.push_back(mk(1'b1, 1'b0, 4'(v)));
      exp_q.push_back(mk(1'b0, 1'b1, 4'd0));
      exp_q.push_back(mk(1'b0, 1'b0, 4'd0));
      load_val = 4'd4;
      start = 1'b1;
      idx = 0;
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         start = (idx == 1);
         if (idx == 1) load_val = 4'd9;
         e = exp_q.pop_front();
         checks++;
         if ({busy, fin, cnt} !== e) begin
            errors++;
            $display("FAIL start_in_run cyc%0d got=%b exp=%b", idx, {busy, fin, cnt}, e);
         end
         idx++;
      end
   endtask

   task automatic test_back_to_back();
      // restart in the same cycle finished_o is high
      int idx;
      int seq[8] = '{2, 1, 0, 3, 2, 1, 0, 0};
      for (int i = 0; i < 8; i++)
         exp_q.push_back(mk(seq[i] != 0, i == 2 || i == 6, 4'(seq[i])));
      load_val = 4'd2;
      start = 1'b1;
      idx = 0;
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         start = (idx == 2);
         if (idx == 2) load_val = 4'd3;
         e = exp_q.pop_front();
         checks++;
         if ({busy, fin, cnt} !== e) begin
            errors++;
            $display("FAIL back_to_back cyc%0d got=%b exp=%b", idx, {busy, fin, cnt}, e);
         end
         idx++;
      end
   endtask

   task automatic test_auto_reload();
      int idx;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      int seq[9] = '{3, 2, 1, 3, 2, 1, 3, 0, 0};
      for (int i = 0; i < 9; i++)
         exp_q.push_back(mk(seq[i] != 0, i == 3 || i == 6, 4'(seq[i])));
`else
      int seq[9] = '{3, 2, 1, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 9; i++)
         exp_q.push_back(mk(seq[i] != 0, i == 3, 4'(seq[i])));
`endif
      load_val = 4'd3;
      start = 1'b1;
      idx = 0;
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         start = 1'b0;
         abort = (idx == 6);
         e = exp_q.pop_front();
         checks++;
         if ({busy, fin, cnt} !== e) begin
            errors++;
            $display("FAIL auto_reload cyc%0d got=%b exp=%b", idx, {busy, fin, cnt}, e);
         end
         idx++;
      end
      abort = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic(4'd5);
      test_basic(4'd1);
      test_prescale2();
      test_pause();
      test_pause_phase();
      test_abort();
      test_clamp();
      test_zero_load();
      test_start_in_run();
      test_back_to_back();
      test_auto_reload();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
